// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned NxN shift-add multiplier around a ripple-carry adder
module ripple_carry_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout
);
    logic [N:0] w_carry;

    assign w_carry[0] = Cin;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_fa
            assign Sum[g]       = A[g] ^ B[g] ^ w_carry[g];
            assign w_carry[g+1] = (A[g] & B[g]) | (w_carry[g] & (A[g] ^ B[g]));
        end
    endgenerate

    assign Cout = w_carry[N];
endmodule

module shift_add_multiplier #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] Product,
    output logic           busy,
    output logic           done
);
    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     r_state;
    logic [N-1:0]   r_areg;
    logic [N-1:0]   r_phi;
    logic [N-1:0]   r_q;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_product;

    logic [N-1:0]   w_addend;
    logic [N-1:0]   w_sum;
    logic           w_cout;

    // Multiplier LSB gates the multiplicand into the partial-product sum.
    assign w_addend = r_q[0] ? r_areg : '0;

    ripple_carry_adder #(.N(N)) u_adder (
        .A    (r_phi),
        .B    (w_addend),
        .Cin  (1'b0),
        .Sum  (w_sum),
        .Cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_areg    <= '0;
            r_phi     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_phi <= {w_cout, w_sum[N-1:1]};
                    r_q   <= {w_sum[0], r_q[N-1:1]};
                    if (r_cnt == CW'(N-1)) begin
                        r_product <= {w_cout, w_sum, r_q[N-1:1]};
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        r_areg  <= A;
                        r_q     <= B;
                        r_phi   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign Product = r_product;
    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
endmodule
